// File: rtl/decoder_scan_seq_pkg.sv
// Shared types and helpers for the scan/direct one-hot decoder.
package dsd_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int unsigned MAX_SEL_W = 5;

    // One-hot of sel, limited to the 2**sel_w lines that exist for this width.
    function automatic logic [31:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                           input int unsigned sel_w);
        logic [31:0] res;
        res = '0;
        if (int'(sel) < (1 << sel_w)) begin
            res[sel] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_scan_seq_dwell_timer.sv
// Per-line dwell counter: counts cycles spent on a line, flags when the hold is done.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [DWELL_W-1:0] dwell,
    output logic               term
);

    logic [DWELL_W-1:0] cnt;

    // >= rather than == so that lowering dwell below cnt ends the hold at once.
    assign term = (cnt >= dwell);

    // Counter: clear wins, otherwise count up and restart after the terminal cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (term) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_seq.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with direct and auto-scan modes.
module decoder_scan_seq
    import dsd_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int DWELL_W   = 8,
    parameter int OUT_ACT_L = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] d_out,
    output logic [SEL_W-1:0]      idx,
    output logic                  active,
    output logic                  wrap
);

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] IDLE = (OUT_ACT_L != 0) ? '1 : '0;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   idx_d;
    logic               active_d;
    logic               wrap_d;
    logic [31:0]        oh_full;
    logic [N-1:0]       d_out_d;
    logic               tmr_clr;
    logic               tmr_inc;
    logic               tmr_term;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .dwell (dwell),
        .term  (tmr_term)
    );

    // Next state and next registered outputs; priority en_n > mode change > advance.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx;
        active_d = 1'b1;
        wrap_d   = 1'b0;
        tmr_clr  = 1'b1;
        tmr_inc  = 1'b0;
        if (en_n) begin
            state_d  = ST_OFF;
            idx_d    = '0;
            active_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF, ST_DIRECT: begin
                    if (mode) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_DIRECT;
                        idx_d   = sel;
                    end
                end
                ST_SCAN: begin
                    if (!mode) begin
                        state_d = ST_DIRECT;
                        idx_d   = sel;
                    end else begin
                        tmr_clr = 1'b0;
                        tmr_inc = 1'b1;
                        if (tmr_term) begin
                            idx_d  = idx + 1'b1;
                            wrap_d = (idx == SEL_W'(N - 1));
                        end
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    idx_d    = '0;
                    active_d = 1'b0;
                end
            endcase
        end
        oh_full = onehot(MAX_SEL_W'(idx_d), SEL_W);
        d_out_d = active_d ? (oh_full[N-1:0] ^ IDLE) : IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers: blank asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out  <= IDLE;
            idx    <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            d_out  <= d_out_d;
            idx    <= idx_d;
            active <= active_d;
            wrap   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq (active-high and active-low instances).
module tb_decoder_scan_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_n;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] d_out, d_out_l;
    logic [1:0] idx, idx_l;
    logic       active, active_l, wrap, wrap_l;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain behavioural description of the decoder.
    bit m_on, m_scan, m_wrap;
    int m_line, m_el;

    always #5 clk = ~clk;

    decoder_scan_seq #(.SEL_W(2), .DWELL_W(8), .OUT_ACT_L(0)) dut (
        .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel), .dwell(dwell),
        .d_out(d_out), .idx(idx), .active(active), .wrap(wrap));

    decoder_scan_seq #(.SEL_W(2), .DWELL_W(8), .OUT_ACT_L(1)) dut_l (
        .clk(clk), .rst(rst), .en_n(en_n), .mode(mode), .sel(sel), .dwell(dwell),
        .d_out(d_out_l), .idx(idx_l), .active(active_l), .wrap(wrap_l));

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_scan = 0; m_line = 0; m_el = 0; m_wrap = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs seen at the edge.
    task automatic model_edge();
        m_wrap = 0;
        if (en_n) begin
            model_reset();
        end else if (!m_on) begin
            m_on = 1; m_scan = mode; m_line = mode ? 0 : int'(sel); m_el = 0;
        end else if (m_scan != mode) begin
            m_scan = mode; m_line = mode ? 0 : int'(sel); m_el = 0;
        end else if (!m_scan) begin
            m_line = int'(sel);
        end else if (m_el >= int'(dwell)) begin
            m_wrap = (m_line == 3);
            m_line = (m_line + 1) % 4;
            m_el = 0;
        end else begin
            m_el++;
        end
    endtask

    task automatic check_model();
        int exp_d;
        exp_d = m_on ? (1 << m_line) : 0;
        check("d_out", int'(d_out), exp_d);
        check("d_out_l", int'(d_out_l), (~exp_d) & 15);
        check("idx", int'(idx), m_on ? m_line : 0);
        check("active", int'(active), int'(m_on));
        check("wrap", int'(wrap), int'(m_wrap));
        check("wrap_l", int'(wrap_l), int'(m_wrap));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        logic       en_n;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] exp_d;
        logic [1:0] exp_idx;
        logic       exp_act;
    } vec_t;

    vec_t vecs[5];
    int   line_before;

    initial begin
        rst = 1'b1; en_n = 1'b1; mode = 1'b0; sel = '0; dwell = 8'd0;
        model_reset();
        #2;
        // T1: reset state
        check("rst_d_out", int'(d_out), 0);
        check("rst_d_out_l", int'(d_out_l), 15);
        check("rst_idx", int'(idx), 0);
        check("rst_active", int'(active), 0);
        check("rst_wrap", int'(wrap), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("dis_d_out", int'(d_out), 0);
        check("dis_d_out_l", int'(d_out_l), 15);

        // T2: direct sweep, table driven
        vecs[0] = '{1'b0, 1'b0, 2'd0, 4'b0001, 2'd0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 4'b0010, 2'd1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 2'd2, 4'b0100, 2'd2, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 2'd3, 4'b1000, 2'd3, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 2'd3, 4'b0000, 2'd0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            en_n = vecs[i].en_n; mode = vecs[i].mode; sel = vecs[i].sel;
            step();
            check("vec_d_out", int'(d_out), int'(vecs[i].exp_d));
            check("vec_idx", int'(idx), int'(vecs[i].exp_idx));
            check("vec_active", int'(active), int'(vecs[i].exp_act));
        end

        // T3: scan with dwell=2, each line three cycles, wrap on first return to line 0
        dwell = 8'd2; mode = 1'b1; en_n = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step();
            check("t3_d_out", int'(d_out), 1 << ((k / 3) % 4));
            check("t3_wrap", int'(wrap), (k == 12) ? 1 : 0);
        end

        // T4: dwell=0 advances every cycle, wrap every 4th
        en_n = 1'b1; step();
        dwell = 8'd0; en_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("t4_d_out", int'(d_out), 1 << (k % 4));
            check("t4_wrap", int'(wrap), (k > 0 && k % 4 == 0) ? 1 : 0);
        end
        // dwell lowered under the running count: advance on the next edge
        en_n = 1'b1; step();
        dwell = 8'd200; en_n = 1'b0;
        step();
        for (int k = 0; k < 50; k++) step();
        check("t4_el50", m_el, 50);
        check("t4_hold", int'(d_out), 4'b0001);
        dwell = 8'd1;
        step();
        check("t4_dec_adv", int'(d_out), 4'b0010);

        // T5: mode switch mid-scan, then back into scan with no wrap
        en_n = 1'b1; step();
        dwell = 8'd2; en_n = 1'b0; mode = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check("t5_line2", int'(d_out), 4'b0100);
        mode = 1'b0; sel = 2'd3;
        step();
        check("t5_direct", int'(d_out), 4'b1000);
        mode = 1'b1;
        step();
        check("t5_rescan", int'(d_out), 4'b0001);
        check("t5_nowrap", int'(wrap), 0);

        // T6: asynchronous reset between edges
        for (int k = 0; k < 4; k++) step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_blank", int'(d_out), 0);
        check("t6_blank_l", int'(d_out_l), 15);
        check("t6_active", int'(active), 0);
        #1;
        rst = 1'b0; en_n = 1'b0; mode = 1'b1;
        step();
        check("t6_restart", int'(d_out), 4'b0001);

        // Randomized stimulus against the model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) en_n = ~en_n;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) dwell = 8'($urandom_range(0, 5));
            step();
        end
        line_before = m_line;
        check("rand_line_range", int'(line_before < 4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
